// File: rtl/rx_downsample_ber.sv
// rtl/rx_downsample_ber.sv - per-rail RX decimator, hard slicer and delay-searched BER counter
// Optional feature macro: LOSS_OF_LOCK_EN (a bad window in LOCKED falls back to SEARCH).
module rx_downsample_ber #(
  parameter  int OS      = 4,
  parameter  int NBT_IN  = 8,
  parameter  int NBF_IN  = 7,
  parameter  int BUF_LEN = 511,
  parameter  int WINDOW  = 511,
  parameter  int NB_CNT  = 64,
  localparam int PW      = $clog2(OS),
  localparam int DW      = $clog2(BUF_LEN)
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic [NBT_IN-1:0] i_is_data,
  input  logic [PW-1:0]     i_phase,
  input  logic              i_ref_bit,
  output logic              o_bit,
  output logic              o_sym_valid,
  output logic              o_locked,
  output logic [DW-1:0]     o_delay,
  output logic [NB_CNT-1:0] o_err_count,
  output logic [NB_CNT-1:0] o_bit_count
);

  localparam int WW     = $clog2(WINDOW + 1);
  localparam int NBI_IN = NBT_IN - NBF_IN;
  localparam int SIGN   = NBI_IN + NBF_IN - 1;

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [BUF_LEN-1:0]  ref_q, ref_d;
  logic [DW-1:0]       delay_q, delay_d;
  logic [WW-1:0]       win_cnt_q, win_cnt_d;
  logic [WW-1:0]       win_err_q, win_err_d;
  logic [NB_CNT-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NB_CNT-1:0]   err_cnt_q, err_cnt_d;
  logic                bit_q, bit_d;
  logic                sym_valid_q, sym_valid_d;

  logic                strobe;
  logic                slice;
  logic                mismatch;
  logic                win_end;
  logic [BUF_LEN-1:0]  shifted;
  logic [WW-1:0]       win_cnt_inc;
  logic [WW-1:0]       win_err_inc;
  logic [DW-1:0]       next_delay;
  logic                unused_frac;

  // Only the sign bit decides the hard bit; the fraction is magnitude only.
  assign unused_frac = ^i_is_data[NBT_IN-2:0];

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    ref_d       = ref_q;
    delay_d     = delay_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;
    bit_d       = bit_q;

    strobe      = i_en && (phase_q == i_phase);
    sym_valid_d = strobe;
    slice       = i_is_data[SIGN];
    shifted     = {ref_q[BUF_LEN-2:0], i_ref_bit};
    mismatch    = slice ^ shifted[delay_q];
    win_cnt_inc = win_cnt_q + WW'(1);
    win_err_inc = win_err_q + WW'(mismatch);
    win_end     = (win_cnt_inc == WW'(WINDOW));
    next_delay  = (delay_q == DW'(BUF_LEN - 1)) ? '0 : delay_q + DW'(1);

    // Holding the count at 0 while disabled realigns the decimation phase on re-enable.
    if (!i_en) begin
      phase_d = '0;
    end else begin
      phase_d = (phase_q == PW'(OS - 1)) ? '0 : phase_q + PW'(1);
    end

    if (strobe) begin
      bit_d     = slice;
      ref_d     = shifted;
      win_cnt_d = win_cnt_inc;
      win_err_d = win_err_inc;
      case (state_q)
        SEARCH: begin
          if (win_end) begin
            win_cnt_d = '0;
            win_err_d = '0;
            if (win_err_inc == '0) begin
              state_d   = LOCKED;
              bit_cnt_d = '0;
              err_cnt_d = '0;
            end else begin
              delay_d = next_delay;
            end
          end
        end
        LOCKED: begin
          bit_cnt_d = (&bit_cnt_q) ? bit_cnt_q : bit_cnt_q + NB_CNT'(1);
          err_cnt_d = (&err_cnt_q || !mismatch) ? err_cnt_q : err_cnt_q + NB_CNT'(1);
`ifdef LOSS_OF_LOCK_EN
          if (win_end) begin
            win_cnt_d = '0;
            win_err_d = '0;
            if (win_err_inc > WW'(WINDOW / 4)) begin
              state_d   = SEARCH;
              delay_d   = next_delay;
              bit_cnt_d = '0;
              err_cnt_d = '0;
            end
          end
`else
          win_cnt_d = '0;
          win_err_d = '0;
`endif
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q     <= SEARCH;
      phase_q     <= '0;
      ref_q       <= '0;
      delay_q     <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
      bit_q       <= 1'b0;
      sym_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      ref_q       <= ref_d;
      delay_q     <= delay_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
      bit_q       <= bit_d;
      sym_valid_q <= sym_valid_d;
    end
  end

  assign o_bit       = bit_q;
  assign o_sym_valid = sym_valid_q;
  assign o_locked    = (state_q == LOCKED);
  assign o_delay     = delay_q;
  assign o_err_count = err_cnt_q;
  assign o_bit_count = bit_cnt_q;

endmodule

// File: tb/tb_rx_downsample_ber.sv
// tb/tb_rx_downsample_ber.sv - randomized bench for rx_downsample_ber against a queue-based symbol model
module tb_rx_downsample_ber;

  localparam int OS      = 4;
  localparam int NBT_IN  = 8;
  localparam int NBF_IN  = 7;
  localparam int BUF_LEN = 31;
  localparam int WINDOW  = 64;
  localparam int NB_CNT  = 10;
  localparam int PW      = $clog2(OS);
  localparam int DW      = $clog2(BUF_LEN);
  localparam int NM      = NBT_IN - 1;
  localparam int CMAX    = (1 << NB_CNT) - 1;
  localparam int VW      = 3 + DW + 2 * NB_CNT;
  localparam int D_ALIGN = 13;

  logic              clk = 1'b0;
  logic              i_reset;
  logic              i_en;
  logic [NBT_IN-1:0] i_is_data;
  logic [PW-1:0]     i_phase;
  logic              i_ref_bit;
  logic              o_bit;
  logic              o_sym_valid;
  logic              o_locked;
  logic [DW-1:0]     o_delay;
  logic [NB_CNT-1:0] o_err_count;
  logic [NB_CNT-1:0] o_bit_count;
  logic [VW-1:0]     act_vec;

  always #5 clk = ~clk;

  rx_downsample_ber #(
    .OS(OS), .NBT_IN(NBT_IN), .NBF_IN(NBF_IN),
    .BUF_LEN(BUF_LEN), .WINDOW(WINDOW), .NB_CNT(NB_CNT)
  ) dut (
    .clk(clk), .i_reset(i_reset), .i_en(i_en), .i_is_data(i_is_data),
    .i_phase(i_phase), .i_ref_bit(i_ref_bit), .o_bit(o_bit),
    .o_sym_valid(o_sym_valid), .o_locked(o_locked), .o_delay(o_delay),
    .o_err_count(o_err_count), .o_bit_count(o_bit_count)
  );

  assign act_vec = {o_bit, o_sym_valid, o_locked, o_delay, o_err_count, o_bit_count};

  int n_checks = 0;
  int n_fail   = 0;

  // Symbol-level reference: history of reference bits, newest at the front.
  bit hist[$];
  bit m_search;
  int m_phase, m_delay, m_win_n, m_win_e, m_bits, m_errs, m_bit, m_valid, m_strobe;

  bit         prbs[$];
  logic [8:0] lfsr = 9'h1FF;
  int         sym;

  function automatic logic [VW-1:0] expv();
    return {1'(m_bit), 1'(m_valid), !m_search, DW'(m_delay), NB_CNT'(m_errs), NB_CNT'(m_bits)};
  endfunction

  task automatic model_step();
    bit b;
    bit mism;
    m_strobe = 0;
    m_valid  = 0;
    if (i_reset) begin
      m_phase = 0; m_delay = 0; m_win_n = 0; m_win_e = 0;
      m_bits = 0; m_errs = 0; m_bit = 0; m_search = 1;
      hist.delete();
      for (int i = 0; i < BUF_LEN; i++) hist.push_back(1'b0);
      return;
    end
    if (!i_en) begin
      m_phase = 0;
      return;
    end
    m_strobe = (m_phase == int'(i_phase)) ? 1 : 0;
    m_phase  = (m_phase + 1) % OS;
    if (m_strobe == 0) return;
    b = i_is_data[NBT_IN-1];
    hist.push_front(i_ref_bit);
    void'(hist.pop_back());
    mism    = (b != hist[m_delay]);
    m_bit   = b;
    m_valid = 1;
    m_win_n++;
    m_win_e += mism;
    if (m_search) begin
      if (m_win_n == WINDOW) begin
        if (m_win_e == 0) begin
          m_search = 0; m_bits = 0; m_errs = 0;
        end else begin
          m_delay = (m_delay + 1) % BUF_LEN;
        end
        m_win_n = 0; m_win_e = 0;
      end
    end else begin
      m_bits = (m_bits < CMAX) ? m_bits + 1 : CMAX;
      m_errs = (m_errs < CMAX) ? m_errs + mism : CMAX;
      if (m_win_n == WINDOW) begin
`ifdef LOSS_OF_LOCK_EN
        if (m_win_e > WINDOW / 4) begin
          m_search = 1; m_delay = (m_delay + 1) % BUF_LEN; m_bits = 0; m_errs = 0;
        end
`endif
        m_win_n = 0; m_win_e = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // PRBS9 (x^9 + x^5 + 1) reference; data is the same stream D_ALIGN symbols late.
  task automatic set_aligned(input bit inv);
    bit db;
    while (prbs.size() <= sym) begin
      prbs.push_back(lfsr[8] ^ lfsr[4]);
      lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    end
    i_ref_bit = prbs[sym];
    db        = (sym >= D_ALIGN) ? prbs[sym - D_ALIGN] : 1'b0;
    db        = db ^ inv;
    i_is_data = {db, NM'($urandom)};
  endtask

  task automatic test_reset();
    i_reset = 1; i_en = 1; i_phase = 0; i_is_data = 8'hC0; i_ref_bit = 1;
    repeat (3) tick();
    n_checks++;
    if (act_vec !== '0) begin
      n_fail++; $display("FAIL reset_outputs got %h expected 0", act_vec);
    end
    n_checks++;
    if (act_vec !== expv()) begin
      n_fail++; $display("FAIL reset_model got %h expected %h", act_vec, expv());
    end
  endtask

  task automatic test_slicer();
    int first;
    i_reset = 1; tick();
    i_reset = 0; i_en = 1; i_phase = 2; i_is_data = 8'h40;
    first = -1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (o_sym_valid && first < 0) first = t;
      n_checks++;
      if (act_vec !== expv()) begin
        n_fail++; $display("FAIL slicer_pos t=%0t got %h expected %h", $time, act_vec, expv());
      end
    end
    n_checks++;
    if (first != 3) begin
      n_fail++; $display("FAIL first_valid got cycle %0d expected 3", first);
    end
    i_is_data = 8'hC0;
    repeat (8) tick();
    n_checks++;
    if (o_bit !== 1'b1) begin
      n_fail++; $display("FAIL slicer_neg got %b expected 1", o_bit);
    end
    for (int t = 0; t < 240; t++) begin
      if (t % 16 == 0) i_phase = PW'($urandom_range(OS - 1));
      i_is_data = NBT_IN'($urandom);
      i_ref_bit = 1'($urandom);
      tick();
      n_checks++;
      if (act_vec !== expv()) begin
        n_fail++; $display("FAIL slicer_rand t=%0t got %h expected %h", $time, act_vec, expv());
      end
    end
  endtask

  task automatic test_enable();
    int low_valid, first, p;
    i_en = 1;
    for (int t = 0; t < 30; t++) begin
      i_is_data = NBT_IN'($urandom); i_ref_bit = 1'($urandom);
      tick();
    end
    i_en = 0;
    low_valid = 0;
    for (int t = 0; t < 7; t++) begin
      i_is_data = NBT_IN'($urandom);
      tick();
      if (t > 0 && o_sym_valid) low_valid++;
      n_checks++;
      if (act_vec !== expv()) begin
        n_fail++; $display("FAIL enable_low t=%0t got %h expected %h", $time, act_vec, expv());
      end
    end
    n_checks++;
    if (low_valid != 0) begin
      n_fail++; $display("FAIL valid_while_disabled got %0d expected 0", low_valid);
    end
    p = $urandom_range(OS - 1);
    i_phase = PW'(p); i_en = 1; first = -1;
    for (int t = 1; t <= 300; t++) begin
      i_is_data = NBT_IN'($urandom); i_ref_bit = 1'($urandom);
      tick();
      if (o_sym_valid && first < 0) first = t;
      n_checks++;
      if (act_vec !== expv()) begin
        n_fail++; $display("FAIL enable_resume t=%0t got %h expected %h", $time, act_vec, expv());
      end
    end
    n_checks++;
    if (first != p + 1) begin
      n_fail++; $display("FAIL reenable_latency got %0d expected %0d", first, p + 1);
    end
  endtask

  task automatic test_lock();
    int cyc;
    i_reset = 1; tick();
    i_reset = 0; i_en = 1; i_phase = 1;
    sym = 0; prbs.delete(); cyc = 0;
    while (!o_locked && cyc < WINDOW * OS * (D_ALIGN + 3)) begin
      set_aligned(1'b0);
      tick();
      cyc++;
      if (m_strobe != 0) sym++;
      n_checks++;
      if (act_vec !== expv()) begin
        n_fail++; $display("FAIL lock_search t=%0t got %h expected %h", $time, act_vec, expv());
      end
    end
    n_checks++;
    if (o_locked !== 1'b1 || o_delay !== DW'(D_ALIGN) || sym != (D_ALIGN + 1) * WINDOW) begin
      n_fail++;
      $display("FAIL lock_result got locked=%b delay=%0d syms=%0d expected 1/%0d/%0d",
               o_locked, o_delay, sym, D_ALIGN, (D_ALIGN + 1) * WINDOW);
    end
    n_checks++;
    if (o_err_count !== '0 || o_bit_count !== '0) begin
      n_fail++; $display("FAIL lock_entry_counts got %0d/%0d expected 0/0", o_err_count, o_bit_count);
    end
  endtask

  task automatic test_errors();
    int base, off;
    bit inv;
    base = sym;
    while (sym - base < 1030) begin
      off = sym - base;
      inv = (off == 3 || off == 100 || off == 499 || off == 500 || off == 998);
      set_aligned(inv);
      tick();
      if (m_strobe != 0) sym++;
      n_checks++;
      if (act_vec !== expv()) begin
        n_fail++; $display("FAIL errors_vec t=%0t got %h expected %h", $time, act_vec, expv());
      end
      if (m_strobe != 0 && sym - base == 1000) begin
        n_checks++;
        if (o_bit_count !== NB_CNT'(1000) || o_err_count !== NB_CNT'(5)) begin
          n_fail++; $display("FAIL count_1000 got %0d/%0d expected 1000/5", o_bit_count, o_err_count);
        end
      end
    end
    n_checks++;
    if (o_bit_count !== NB_CNT'(CMAX) || o_err_count !== NB_CNT'(5)) begin
      n_fail++; $display("FAIL count_saturate got %0d/%0d expected %0d/5", o_bit_count, o_err_count, CMAX);
    end
  endtask

  task automatic test_reset_locked();
    i_reset = 1;
    tick();
    n_checks++;
    if (act_vec !== '0) begin
      n_fail++; $display("FAIL reset_mid_lock got %h expected 0", act_vec);
    end
    i_reset = 0;
  endtask

  task automatic test_loss_of_lock();
    int base;
    test_lock();
    base = sym;
    while (sym - base < WINDOW) begin
      set_aligned((sym - base) < 20);
      tick();
      if (m_strobe != 0) sym++;
      n_checks++;
      if (act_vec !== expv()) begin
        n_fail++; $display("FAIL lol_vec t=%0t got %h expected %h", $time, act_vec, expv());
      end
    end
`ifdef LOSS_OF_LOCK_EN
    n_checks++;
    if (o_locked !== 1'b0 || o_delay !== DW'(D_ALIGN + 1) || o_err_count !== '0) begin
      n_fail++; $display("FAIL lol_drop got locked=%b delay=%0d errs=%0d expected 0/%0d/0",
                         o_locked, o_delay, o_err_count, D_ALIGN + 1);
    end
`else
    n_checks++;
    if (o_locked !== 1'b1 || o_err_count !== NB_CNT'(20) || o_bit_count !== NB_CNT'(WINDOW)) begin
      n_fail++; $display("FAIL lol_hold got locked=%b errs=%0d bits=%0d expected 1/20/%0d",
                         o_locked, o_err_count, o_bit_count, WINDOW);
    end
`endif
  endtask

  task automatic test_search_wrap();
    int  cyc, syms, prev;
    bit  wrapped, ever_locked;
    i_reset = 1; tick();
    i_reset = 0; i_en = 1; i_phase = PW'($urandom_range(OS - 1));
    cyc = 0; syms = 0; wrapped = 0; ever_locked = 0;
    while (syms < 2 * BUF_LEN * WINDOW && cyc < 2 * BUF_LEN * WINDOW * OS + 16) begin
      i_is_data = NBT_IN'($urandom); i_ref_bit = 1'($urandom);
      prev = int'(o_delay);
      tick();
      cyc++;
      if (m_strobe != 0) syms++;
      if (prev == BUF_LEN - 1 && o_delay == '0) wrapped = 1;
      if (o_locked) ever_locked = 1;
      n_checks++;
      if (act_vec !== expv()) begin
        n_fail++; $display("FAIL wrap_vec t=%0t got %h expected %h", $time, act_vec, expv());
      end
    end
    n_checks++;
    if (!wrapped || ever_locked || syms != 2 * BUF_LEN * WINDOW) begin
      n_fail++; $display("FAIL delay_wrap got wrapped=%b locked=%b syms=%0d expected 1/0/%0d",
                         wrapped, ever_locked, syms, 2 * BUF_LEN * WINDOW);
    end
  endtask

  initial begin
    test_reset();
    test_slicer();
    test_enable();
    test_lock();
    test_errors();
    test_reset_locked();
    test_loss_of_lock();
    test_search_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_downsample_ber.md
Name: rx_downsample_ber

Overview:
Receive-side counterpart of the TX pulse-shaping FIR. Takes one rail (I or Q) of the oversampled filtered stream, decimates by OS at a programmable phase, and slices each kept sample to a hard bit. Aligns the sliced bits against the reference PRBS bit stream by delay search, then counts bits and bit errors for BER measurement. Sits after the channel/RX filter, one instance per rail.

Parameters:
OS, 4, oversampling factor; samples per symbol.
NBT_IN, 8, total bits of input sample S(NBT_IN,NBF_IN).
NBF_IN, 7, fractional bits of input sample (format only; the slicer uses the sign bit).
BUF_LEN, 511, reference delay-line depth; delay search range 0..BUF_LEN-1.
WINDOW, 511, symbols per evaluation window.
NB_CNT, 64, width of the bit and error counters.

Ports:
clk  input  1  system clock, sample rate
i_reset  input  1  synchronous, active-high reset
i_en  input  1  enable; low = pause and phase realign
i_is_data  input  NBT_IN  signed filtered sample, one per clk
i_phase  input  $clog2(OS)  decimation phase select, 0..OS-1
i_ref_bit  input  1  reference TX bit for the current symbol, sampled on symbol strobe
o_bit  output  1  sliced hard bit
o_sym_valid  output  1  1-clk pulse, o_bit valid
o_locked  output  1  delay alignment achieved
o_delay  output  $clog2(BUF_LEN)  current/locked candidate delay
o_err_count  output  NB_CNT  bit errors since lock
o_bit_count  output  NB_CNT  bits compared since lock

Behaviour:
- Reset: all outputs 0, phase counter 0, ref delay line 0, FSM = SEARCH, delay 0, window/error counters 0. Reset has priority over i_en and applies mid-window or mid-lock.
- Phase counter: while i_en=1, increments mod OS each clk. While i_en=0 it is forced to 0, no strobes occur, and the FSM, counters and delay line hold.
- Symbol strobe: asserted in a cycle with i_en=1 and phase counter == i_phase. Changing i_phase takes effect on the next count match.
- Slicer: b = i_is_data[NBT_IN-1]. Positive or zero -> 0; negative -> 1. This matches the TX map 0->+1, 1->-1.
- Latency: o_bit and o_sym_valid are registered. o_sym_valid pulses exactly 1 clk, 1 clk after the strobe cycle; otherwise 0. o_bit holds its last value between pulses.
- Ref delay line: on each strobe, shift i_ref_bit into position 0. Compare b against the post-shift entry at [o_delay], so delay 0 means same-strobe alignment.
- FSM SEARCH:
  - Each strobe increments the window counter; a mismatch increments the window error count.
  - At WINDOW symbols, if the error count is 0: go to LOCKED and keep o_delay.
  - Otherwise: o_delay = o_delay+1, wrapping from BUF_LEN-1 to 0.
  - Either way, clear the window counters.
- FSM LOCKED:
  - o_locked=1. Each strobe increments o_bit_count; a mismatch also increments o_err_count.
  - Both counters saturate at all-ones.
  - Both counters are 0 on entry to LOCKED.
- o_locked, o_delay and the counters update in the same cycle o_sym_valid pulses for that symbol.
- A strobe coinciding with the window end is included in that window.

Optional Feature:
LOSS_OF_LOCK_EN.
- Defined: LOCKED also runs a WINDOW-symbol error counter. If errors in a window exceed WINDOW/4 (integer division), go to SEARCH at o_delay+1 (wrapping), clear o_locked, and clear o_err_count/o_bit_count.
- Undefined: LOCKED is left only by i_reset.

Test Plan:
1. Reset, OS=4, i_phase=2, i_en=1, constant i_is_data=8'h40 -> o_sym_valid pulses every 4 clk, first at clk 4 after reset release (strobe at count 2, +1 reg); o_bit=0. i_is_data=8'hC0 -> o_bit=1.
2. Drive i_ref_bit = PRBS9, i_is_data = +/-0.5 mapping of the same PRBS delayed 37 symbols -> o_locked=1 with o_delay=37 after 38 windows (38*511 symbols); o_err_count stays 0.
3. Locked as in 2, invert the slicer input on 5 chosen symbols within 1000 -> o_bit_count=1000, o_err_count=5.
4. Random reference/input (no alignment) for 2*BUF_LEN windows -> o_locked stays 0; o_delay wraps 510->0.
5. i_en low for 7 clk mid-search, then high -> no o_sym_valid while low; first strobe i_phase clk after re-enable; window counter resumes at its held value. i_reset mid-LOCKED -> all outputs 0 next clk, FSM SEARCH.
6. With LOSS_OF_LOCK_EN: locked, then inject 128 errors in one window -> o_locked drops at window end, o_delay = previous+1. Without the macro -> stays locked, o_err_count=128.
